// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op and buffer-state encodings for the shift execute stage
package shift_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

endpackage

// File: rtl/shifter.sv
// rtl/shifter.sv - 16-bit barrel shifter: rotate/logical shift left/right by 0..15
module shifter
  import shift_pkg::*;
(
  input  logic [15:0] In,
  input  logic [3:0]  Cnt,
  input  logic [1:0]  Op,
  output logic [15:0] Out
);

  // Complement shift of 16 makes count 0 drop the wrapped half, giving pass-through.
  logic [4:0] inv_cnt;
  assign inv_cnt = 5'd16 - {1'b0, Cnt};

  always_comb begin
    Out = In;
    case (Op)
      OP_ROL:  Out = (In << Cnt) | (In >> inv_cnt);
      OP_SLL:  Out = In << Cnt;
      OP_ROR:  Out = (In >> Cnt) | (In << inv_cnt);
      OP_SRL:  Out = In >> Cnt;
      default: Out = In;
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - shift/rotate execute stage with 2-entry skid buffer; SHIFT_EXEC_ZFLAG_EN adds out_zero
module shift_exec_stage
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [3:0]  in_imm,
  input  logic        in_use_imm,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result
`ifdef SHIFT_EXEC_ZFLAG_EN
  ,
  output logic        out_zero
`endif
);

`ifdef SHIFT_EXEC_ZFLAG_EN
  localparam int ENT_W = DATA_W + 1;
`else
  localparam int ENT_W = DATA_W;
`endif

  logic [3:0]       cnt;
  logic [15:0]      shift_res;
  logic [ENT_W-1:0] push_ent;
  logic             push;
  logic             pop;
  logic             unused_b;

  state_e           state_q, state_d;
  logic [ENT_W-1:0] ent0_q, ent0_d;
  logic [ENT_W-1:0] ent1_q, ent1_d;

  assign cnt      = in_use_imm ? in_imm : in_b[3:0];
  assign unused_b = ^in_b[15:4];

  shifter u_shifter (
    .In  (in_a),
    .Cnt (cnt),
    .Op  (in_op),
    .Out (shift_res)
  );

`ifdef SHIFT_EXEC_ZFLAG_EN
  assign push_ent = {(shift_res == 16'h0000), shift_res};
  assign out_zero = ent0_q[DATA_W];
`else
  assign push_ent = shift_res;
`endif

  // Handshake decoded from registered state; rst only masks, never out_ready.
  assign in_ready   = !rst && (state_q != ST_TWO);
  assign out_valid  = !rst && (state_q != ST_EMPTY);
  assign out_result = ent0_q[DATA_W-1:0];
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            ent0_d  = push_ent;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            ent0_d = push_ent;
          end else if (push) begin
            ent1_d  = push_ent;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            ent0_d  = ent1_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - directed self-checking bench for shift_exec_stage
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0;
  logic [15:0] in_b = 16'h0;
  logic [3:0]  in_imm = 4'h0;
  logic        in_use_imm = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
`ifdef SHIFT_EXEC_ZFLAG_EN
  logic        out_zero;
`endif

  int vectors = 0;
  int miscompares = 0;

  shift_exec_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef SHIFT_EXEC_ZFLAG_EN
    ,
    .out_zero   (out_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] imm, input logic use_imm);
    in_valid   = 1'b1;
    in_op      = op;
    in_a       = a;
    in_b       = b;
    in_imm     = imm;
    in_use_imm = use_imm;
  endtask

  initial begin
    // Reset: outputs masked while rst is sampled, state cleared afterwards
    step(); step();
    chk("rst_in_ready", {15'h0, in_ready}, 16'h0);
    chk("rst_out_valid", {15'h0, out_valid}, 16'h0);
    chk("rst_out_result", out_result, 16'h0000);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {15'h0, in_ready}, 16'h1);
    chk("post_rst_out_valid", {15'h0, out_valid}, 16'h0);

    // Op coverage with continuous drain
    out_ready = 1'b1;
    drive(2'b00, 16'h8001, 16'h0000, 4'd1, 1'b1);
    step();
    chk("rol_valid", {15'h0, out_valid}, 16'h1);
    chk("rol_8001_1", out_result, 16'h0003);
    drive(2'b01, 16'h00FF, 16'h0004, 4'd9, 1'b0);
    step();
    chk("sll_00ff_b4", out_result, 16'h0FF0);
    drive(2'b11, 16'h8000, 16'h0000, 4'd15, 1'b1);
    step();
    chk("srl_8000_15", out_result, 16'h0001);
    drive(2'b10, 16'h0001, 16'h0000, 4'd1, 1'b1);
    step();
    chk("ror_0001_1", out_result, 16'h8000);
    drive(2'b00, 16'h1234, 16'hFFF0, 4'd7, 1'b0);
    step();
    chk("rol_cnt0", out_result, 16'h1234);
    drive(2'b11, 16'hA5A5, 16'h0000, 4'd0, 1'b1);
    step();
    chk("srl_cnt0", out_result, 16'hA5A5);
    drive(2'b10, 16'h00F1, 16'h0000, 4'd4, 1'b1);
    step();
    chk("ror_wrap", out_result, 16'h100F);
    drive(2'b01, 16'hFFFF, 16'h0000, 4'd15, 1'b1);
    step();
    chk("sll_15", out_result, 16'h8000);
    in_valid = 1'b0;
    step();
    chk("drain_empty", {15'h0, out_valid}, 16'h0);

    // Backpressure: two accepted, third held until space frees
    out_ready = 1'b0;
    drive(2'b01, 16'h0001, 16'h0000, 4'd1, 1'b1);
    step();
    chk("bp1_ready", {15'h0, in_ready}, 16'h1);
    chk("bp1_head", out_result, 16'h0002);
    drive(2'b01, 16'h0001, 16'h0000, 4'd2, 1'b1);
    step();
    chk("bp2_ready", {15'h0, in_ready}, 16'h0);
    chk("bp2_head", out_result, 16'h0002);
    drive(2'b01, 16'h0001, 16'h0000, 4'd3, 1'b1);
    step();
    chk("bp3_ready", {15'h0, in_ready}, 16'h0);
    chk("bp3_stable", out_result, 16'h0002);
    out_ready = 1'b1;
    step();
    chk("bp_pop1", out_result, 16'h0004);
    chk("bp_pop1_ready", {15'h0, in_ready}, 16'h1);
    step();
    chk("bp_pop2", out_result, 16'h0008);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {15'h0, out_valid}, 16'h0);

    // Simultaneous push and pop in ONE
    for (int i = 0; i <= 8; i++) begin
      drive(2'b00, 16'h0001, 16'h0000, 4'(i), 1'b1);
      step();
      chk($sformatf("stream_%0d", i), out_result, 16'h0001 << i);
      chk($sformatf("stream_rdy_%0d", i), {15'h0, in_ready & out_valid}, 16'h1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_empty", {15'h0, out_valid}, 16'h0);

    // Flush while TWO with a same-cycle push
    out_ready = 1'b0;
    drive(2'b01, 16'h0001, 16'h0000, 4'd1, 1'b1);
    step();
    drive(2'b01, 16'h0001, 16'h0000, 4'd2, 1'b1);
    step();
    chk("fl_two", {15'h0, in_ready}, 16'h0);
    drive(2'b01, 16'h0001, 16'h0000, 4'd5, 1'b1);
    flush = 1'b1;
    step();
    chk("fl_valid", {15'h0, out_valid}, 16'h0);
    chk("fl_ready", {15'h0, in_ready}, 16'h1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost", {15'h0, out_valid}, 16'h0);

    // Reset while TWO
    out_ready = 1'b0;
    drive(2'b10, 16'h0001, 16'h0000, 4'd1, 1'b1);
    step();
    drive(2'b10, 16'h0003, 16'h0000, 4'd1, 1'b1);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mask_ready", {15'h0, in_ready}, 16'h0);
    chk("rst_mask_valid", {15'h0, out_valid}, 16'h0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_two_valid", {15'h0, out_valid}, 16'h0);
    chk("rst_two_result", out_result, 16'h0000);
    chk("rst_two_ready", {15'h0, in_ready}, 16'h1);

`ifdef SHIFT_EXEC_ZFLAG_EN
    out_ready = 1'b1;
    drive(2'b01, 16'h8000, 16'h0000, 4'd1, 1'b1);
    step();
    chk("z_result", out_result, 16'h0000);
    chk("z_flag_set", {15'h0, out_zero}, 16'h1);
    drive(2'b01, 16'h4000, 16'h0000, 4'd1, 1'b1);
    step();
    chk("z_flag_clr", {15'h0, out_zero}, 16'h0);
    in_valid = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
